alu_seq: RTL

Parametrised sequential ALU: a WIDTH-bit datapath that keeps the existing 3-bit logic/arithmetic op encoding, adds shifts and an iterative multiply, and wraps everything in a registered valid/ready handshake with status flags. It is the execution unit between the operand-fetch stage and the writeback stage. It holds one operation in flight, and the result is held until the consumer accepts it.

---
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with a valid/ready handshake.
//
// It holds one operation in flight. Logic ops, ADD, SUB, SLT, illegal ops and
// shifts by 0 produce a result one cycle after accept. Shifts by k step one bit
// per cycle. MUL is a shift-add over WIDTH cycles. The result and flags are held
// until the consumer takes them.
//
// Build option: define ALU_SEQ_MUL_EN to include the iterative multiplier
// (op 1011). Without it, op 1011 is treated as an illegal op.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   in_valid / in_ready  operand offer; in_ready is high only in IDLE
//   op, a, b             op code and operands; b[SHW-1:0] is the shift amount
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   result               registered result
//   flag_z/n/c/v         zero, negative, carry and overflow (c/v: ADD/SUB only)
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [3:0] OP_OR   = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1011;
`endif
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [3:0]       opq;
  logic [WIDTH-1:0] work, work_nx, step_res;
  logic [SHW:0]     cnt;
  logic             cnt_last;

  // single-cycle datapath
  logic [WIDTH-1:0] bop, r1;
  logic [WIDTH:0]   sum;
  logic             cin, ovf, c1, v1, multi;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand, prod, prod_nx;
`endif

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE) && !reset;
  assign accept    = in_valid && in_ready;
  assign cnt_last  = (cnt == CNT_ONE);

  always_comb begin
    cin = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    bop = cin ? ~b : b;
    sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
    ovf = (a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    r1    = '0;
    c1    = 1'b0;
    v1    = 1'b0;
    multi = 1'b0;
    case (op)
      OP_OR:   r1 = a | b;
      OP_AND:  r1 = a & b;
      OP_XOR:  r1 = a ^ b;
      OP_NOR:  r1 = ~(a | b);
      OP_NAND: r1 = ~(a & b);
      OP_ADD, OP_SUB: begin
        r1 = sum[WIDTH-1:0];
        c1 = sum[WIDTH];
        v1 = ovf;
      end
      OP_SLT:  r1 = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_SLTU: r1 = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      // a shift by 0 completes here with the operand unchanged
      OP_SLL, OP_SRL, OP_SRA: begin
        r1    = a;
        multi = (b[SHW-1:0] != '0);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  multi = 1'b1;
`endif
      default: r1 = '0;
    endcase
  end

  // one iteration step; for MUL, work holds the not-yet-consumed multiplier bits
  always_comb begin
    case (opq)
      OP_SLL:  work_nx = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  work_nx = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  work_nx = {work[WIDTH-1], work[WIDTH-1:1]};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  work_nx = {1'b0, work[WIDTH-1:1]};
`endif
      default: work_nx = work;
    endcase
    step_res = work_nx;
`ifdef ALU_SEQ_MUL_EN
    prod_nx = prod + (work[0] ? mcand : '0);
    if (opq == OP_MUL) step_res = prod_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = multi ? BUSY : DONE;
      BUSY: if (cnt_last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      work   <= '0;
      cnt    <= '0;
      opq    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opq <= op;
          if (multi) begin
            work <= a;
            cnt  <= {1'b0, b[SHW-1:0]};
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              work <= b;
              cnt  <= (SHW+1)'(WIDTH);
            end
`endif
          end else begin
            result <= r1;
            flag_z <= (r1 == '0);
            flag_n <= r1[WIDTH-1];
            flag_c <= c1;
            flag_v <= v1;
          end
        end
        BUSY: begin
          work <= work_nx;
          cnt  <= cnt - CNT_ONE;
          if (cnt_last) begin
            result <= step_res;
            flag_z <= (step_res == '0);
            flag_n <= step_res[WIDTH-1];
            flag_c <= 1'b0;
            flag_v <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      prod  <= '0;
    end else if (accept) begin
      mcand <= a;
      prod  <= '0;
    end else if (state == BUSY && opq == OP_MUL) begin
      mcand <= {mcand[WIDTH-2:0], 1'b0};
      prod  <= prod_nx;
    end
  end
`endif

endmodule
